// File: rtl/countdown_timer_7seg.sv
// mm:ss count-down timer with key conditioning and active-low 7-segment outputs.
// Optional feature: define BLINK_EN to blink the display ("0000"/blank) while in DONE.
module countdown_timer_7seg #(
    parameter int unsigned TICK_DIV        = 50_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic [1:0] KEY,
    input  logic [5:0] SW,
    output logic [0:6] HEX0,
    output logic [0:6] HEX1,
    output logic [0:6] HEX2,
    output logic [0:6] HEX3,
    output logic [1:0] LEDR
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    function automatic logic [0:6] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0000001;
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b0100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0000100;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    logic [1:0]         sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]         deb_q, deb_d, press_q, press_d;
    logic [1:0][DW-1:0] dcnt_q, dcnt_d;
    state_t             state_q, state_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic [3:0]         m10_q, m10_d, m1_q, m1_d, s10_q, s10_d, s1_q, s1_d;
    logic [0:6]         hex0_q, hex0_d, hex1_q, hex1_d, hex2_q, hex2_d, hex3_q, hex3_d;
    logic [5:0]         sw_clamp;
    logic [3:0]         pre_m10, pre_m1;
    logic               load, start;

    // Key conditioning: two-stage sync, stability counter, 1->0 edge pulse
    always_comb begin
        sync1_d = KEY;
        sync2_d = sync1_q;
        for (int unsigned i = 0; i < 2; i++) begin
            deb_d[i]  = deb_q[i];
            dcnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (dcnt_q[i] == DW'(DEBOUNCE_CYCLES - 1))
                    deb_d[i] = sync2_q[i];
                else
                    dcnt_d[i] = dcnt_q[i] + DW'(1);
            end
            press_d[i] = deb_q[i] & ~deb_d[i];
        end
    end

    assign load  = press_q[0];
    assign start = press_q[1];

    // Preset: clamp minutes to 59 and split into BCD by comparison against tens
    always_comb begin
        sw_clamp = (SW > 6'd59) ? 6'd59 : SW;
        pre_m10  = '0;
        pre_m1   = sw_clamp[3:0];
        for (int unsigned k = 1; k < 6; k++) begin
            if (sw_clamp >= 6'(10 * k)) begin
                pre_m10 = 4'(k);
                pre_m1  = 4'(sw_clamp - 6'(10 * k));
            end
        end
    end

    // Timer FSM: load has priority, RUN advances prescaler and borrows through BCD digits
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        m10_d   = m10_q;
        m1_d    = m1_q;
        s10_d   = s10_q;
        s1_d    = s1_q;
        if (load) begin
            m10_d   = pre_m10;
            m1_d    = pre_m1;
            s10_d   = '0;
            s1_d    = '0;
            state_d = S_IDLE;
            presc_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && ({m10_q, m1_q, s10_q, s1_q} != '0)) begin
                        state_d = S_RUN;
                        presc_d = '0;
                    end
                end
                S_RUN: begin
                    if (start) begin
                        state_d = S_PAUSE;
                    end else if (presc_q == PW'(TICK_DIV - 1)) begin
                        presc_d = '0;
                        if (s1_q != 4'd0) begin
                            s1_d = s1_q - 4'd1;
                        end else begin
                            s1_d = 4'd9;
                            if (s10_q != 4'd0) begin
                                s10_d = s10_q - 4'd1;
                            end else begin
                                s10_d = 4'd5;
                                if (m1_q != 4'd0) begin
                                    m1_d = m1_q - 4'd1;
                                end else begin
                                    m1_d  = 4'd9;
                                    m10_d = m10_q - 4'd1;
                                end
                            end
                        end
                        if ({m10_d, m1_d, s10_d, s1_d} == '0)
                            state_d = S_DONE;
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                S_PAUSE: begin
                    if (start)
                        state_d = S_RUN;
                end
                default: ;
            endcase
        end
    end

`ifdef BLINK_EN
    localparam int unsigned HALF = TICK_DIV / 2;
    localparam int unsigned BW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blank_q, blank_d;

    // Blink phase: blank first after DONE entry, toggle every HALF cycles, cleared outside DONE
    always_comb begin
        blink_cnt_d = '0;
        blank_d     = 1'b0;
        if (state_d == S_DONE) begin
            if (state_q != S_DONE) begin
                blank_d = 1'b1;
            end else if (blink_cnt_q == BW'(HALF - 1)) begin
                blank_d = ~blank_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
                blank_d     = blank_q;
            end
        end
    end

    // Blink state registers
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            blink_cnt_q <= '0;
            blank_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blank_q     <= blank_d;
        end
    end
`endif

    // Segment encoding of the current digits, registered one cycle later
    always_comb begin
        hex0_d = seg7(s1_q);
        hex1_d = seg7(s10_q);
        hex2_d = seg7(m1_q);
        hex3_d = seg7(m10_q);
`ifdef BLINK_EN
        if (blank_q) begin
            hex0_d = '1;
            hex1_d = '1;
            hex2_d = '1;
            hex3_d = '1;
        end
`endif
    end

    // All core state: key pipeline, FSM, time digits and display registers
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q <= '1;
            sync2_q <= '1;
            deb_q   <= '1;
            dcnt_q  <= '0;
            press_q <= '0;
            state_q <= S_IDLE;
            presc_q <= '0;
            m10_q   <= '0;
            m1_q    <= '0;
            s10_q   <= '0;
            s1_q    <= '0;
            hex0_q  <= 7'b0000001;
            hex1_q  <= 7'b0000001;
            hex2_q  <= 7'b0000001;
            hex3_q  <= 7'b0000001;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            dcnt_q  <= dcnt_d;
            press_q <= press_d;
            state_q <= state_d;
            presc_q <= presc_d;
            m10_q   <= m10_d;
            m1_q    <= m1_d;
            s10_q   <= s10_d;
            s1_q    <= s1_d;
            hex0_q  <= hex0_d;
            hex1_q  <= hex1_d;
            hex2_q  <= hex2_d;
            hex3_q  <= hex3_d;
        end
    end

    assign HEX0 = hex0_q;
    assign HEX1 = hex1_q;
    assign HEX2 = hex2_q;
    assign HEX3 = hex3_q;
    assign LEDR = {state_q == S_RUN, state_q == S_DONE};

endmodule

// File: tb/tb_countdown_timer_7seg.sv
// Scoreboard bench for countdown_timer_7seg: expected display/LED changes are queued by the
// stimulus process and checked by a monitor whenever the observed outputs change.
module tb_countdown_timer_7seg;

    localparam int unsigned TICK = 10;
    localparam int unsigned DEB  = 4;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N;
    logic [1:0] KEY;
    logic [5:0] SW;
    logic [0:6] HEX0, HEX1, HEX2, HEX3;
    logic [1:0] LEDR;

    countdown_timer_7seg #(
        .TICK_DIV        (TICK),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .KEY      (KEY),
        .SW       (SW),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3),
        .LEDR     (LEDR)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // mode: 0 gap ignored, 1 exact gap, 2 minimum gap, 3 exact gap minus recorded pause offset,
    //       4 record gap as pause offset (must be 0..9)
    typedef struct {
        logic [27:0] disp;
        logic [1:0]  led;
        int          mode;
        int          gap;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        e;
    int          compared   = 0;
    int          mismatched = 0;
    int          pushed     = 0;
    int          popped     = 0;
    int          cyc        = 0;
    int          last_evt   = 0;
    int          pause_p    = 0;
    int          g;
    bit          ok;
    logic [29:0] prev_obs, cur_obs;

    function automatic logic [0:6] seg(input int d);
        case (d)
            0:       seg = 7'b0000001;
            1:       seg = 7'b1001111;
            2:       seg = 7'b0010010;
            3:       seg = 7'b0000110;
            4:       seg = 7'b1001100;
            5:       seg = 7'b0100100;
            6:       seg = 7'b0100000;
            7:       seg = 7'b0001111;
            8:       seg = 7'b0000000;
            9:       seg = 7'b0000100;
            default: seg = 7'b1111111;
        endcase
    endfunction

    function automatic logic [27:0] disp(input int m, input int s);
        disp = {seg(m / 10), seg(m % 10), seg(s / 10), seg(s % 10)};
    endfunction

    task automatic push(input int m, input int s, input logic [1:0] led,
                        input int mode, input int gap, input string nm);
        exp_t x;
        x.disp = disp(m, s);
        x.led  = led;
        x.mode = mode;
        x.gap  = gap;
        x.name = nm;
        sb_q.push_back(x);
        pushed++;
    endtask

    task automatic drain(input int maxc, input string nm);
        int n;
        n = 0;
        while (popped != pushed && n < maxc) begin
            @(negedge CLOCK_50);
            #1;
            n++;
        end
        if (popped != pushed) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: %0d expected events still pending, required 0", nm, pushed - popped);
        end
    endtask

    task automatic press(input logic [1:0] m);
        KEY = KEY & ~m;
        repeat (10) @(negedge CLOCK_50);
        KEY = KEY | m;
        repeat (10) @(negedge CLOCK_50);
    endtask

    task automatic check_reset_outputs(input string nm);
        logic [29:0] act;
        act = {HEX3, HEX2, HEX1, HEX0, LEDR};
        compared++;
        if (act !== {disp(0, 0), 2'b00}) begin
            mismatched++;
            $display("FAIL %s: got hex=%h led=%b, required hex=%h led=00", nm, act[29:2], act[1:0], disp(0, 0));
        end
    endtask

    // Monitor: every change of {HEX3..HEX0, LEDR} is one DUT event checked against the queue head
    initial begin
        prev_obs = {disp(0, 0), 2'b00};
        forever begin
            @(negedge CLOCK_50);
            cyc++;
            cur_obs = {HEX3, HEX2, HEX1, HEX0, LEDR};
            if (cur_obs !== prev_obs) begin
                g        = cyc - last_evt;
                last_evt = cyc;
                prev_obs = cur_obs;
                compared++;
                if (sb_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_event: got hex=%h led=%b, required no change", cur_obs[29:2], cur_obs[1:0]);
                end else begin
                    e = sb_q.pop_front();
                    popped++;
                    ok = (cur_obs[29:2] === e.disp) && (cur_obs[1:0] === e.led);
                    case (e.mode)
                        1: ok = ok && (g == e.gap);
                        2: ok = ok && (g >= e.gap);
                        3: ok = ok && (g == e.gap - pause_p);
                        4: begin
                            pause_p = g;
                            ok = ok && (g >= 0) && (g <= 9);
                        end
                        default: ;
                    endcase
                    if (!ok)
                        $display("FAIL %s: got hex=%h led=%b gap=%0d, required hex=%h led=%b gap(mode %0d)=%0d (pause offset %0d)",
                                 e.name, cur_obs[29:2], cur_obs[1:0], g, e.disp, e.led, e.mode, e.gap, pause_p);
                    if (!ok) mismatched++;
                end
            end
        end
    end

    // Watchdog against a hung run
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    initial begin
        KEY     = 2'b11;
        SW      = '0;
        RESET_N = 1'b1;
        #1 RESET_N = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        #1 check_reset_outputs("reset_init");
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        repeat (3) @(negedge CLOCK_50);

        // start at 00:00 must not leave IDLE (no output change)
        press(2'b10);
        repeat (10) @(negedge CLOCK_50);

        // load clamps 63 -> 59:00
        SW = 6'd63;
        push(59, 0, 2'b00, 0, 0, "load_clamp_59");
        press(2'b01);
        drain(50, "load_clamp_59");

        // 02:00 full countdown to DONE
        SW = 6'd2;
        push(2, 0, 2'b00, 0, 0, "load_02");
        press(2'b01);
        drain(50, "load_02");
        push(2, 0, 2'b10, 0, 0, "start_run");
        push(1, 59, 2'b10, 1, TICK + 1, "first_dec");
        for (int t = 118; t >= 1; t--)
            push(t / 60, t % 60, 2'b10, 1, TICK, "dec");
        push(0, 1, 2'b01, 1, TICK - 1, "done_led");
        push(0, 0, 2'b01, 1, 1, "done_hex");
        press(2'b10);
        drain(1500, "countdown");

        // start ignored in DONE; load leaves DONE
        press(2'b10);
        repeat (10) @(negedge CLOCK_50);
        SW = 6'd5;
        push(0, 0, 2'b00, 0, 0, "done_exit_led");
        push(5, 0, 2'b00, 1, 1, "load_05");
        press(2'b01);
        drain(50, "load_05");

        // bouncing start key yields exactly one start pulse
        push(5, 0, 2'b10, 0, 0, "bounce_start");
        push(4, 59, 2'b10, 1, TICK + 1, "dec_0459");
        for (int i = 0; i < 20; i++) begin
            KEY[1] = ~KEY[1];
            @(negedge CLOCK_50);
        end
        KEY[1] = 1'b0;
        repeat (10) @(negedge CLOCK_50);
        KEY[1] = 1'b1;
        repeat (10) @(negedge CLOCK_50);
        push(4, 58, 2'b10, 1, TICK, "dec_0458");
        drain(50, "dec_0458");

        // pause freezes time and prescaler; resume continues the partial second
        push(4, 58, 2'b00, 4, 0, "pause");
        push(4, 58, 2'b10, 2, 5, "resume");
        push(4, 57, 2'b10, 3, TICK + 1, "resume_dec");
        push(4, 56, 2'b10, 1, TICK, "dec_0456");
        push(4, 55, 2'b10, 1, TICK, "dec_0455");
        press(2'b10);
        repeat (2) @(negedge CLOCK_50);
        press(2'b10);
        drain(100, "pause_resume");

        // simultaneous load and start in RUN: load wins
        SW = 6'd3;
        push(4, 55, 2'b00, 0, 0, "load_start_led");
        push(3, 0, 2'b00, 1, 1, "load_start_preset");
        press(2'b11);
        drain(50, "load_start");

        // asynchronous reset in the middle of RUN
        push(3, 0, 2'b10, 0, 0, "run_03");
        KEY[1] = 1'b0;
        drain(50, "run_03");
        repeat (3) @(negedge CLOCK_50);
        push(0, 0, 2'b00, 0, 0, "reset_run");
        #2 RESET_N = 1'b0;
        #1 check_reset_outputs("reset_async");
        KEY = 2'b11;
        repeat (2) @(negedge CLOCK_50);
        RESET_N = 1'b1;
        drain(10, "reset_run");

        // preset not retained: start after reset stays at 00:00
        repeat (3) @(negedge CLOCK_50);
        press(2'b10);
        repeat (20) @(negedge CLOCK_50);

        compared++;
        if (pushed != popped) begin
            mismatched++;
            $display("FAIL scoreboard_empty: got %0d pending, required 0", pushed - popped);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
